// File: rtl/arcade_input_mux.sv
// arcade_input_mux: merges PS/2 key events and MiSTer joystick words into
// per-player direction, button, start, coin and pause signals, with a
// runtime-loadable keymap and DIP byte capture over ioctl.
// Optional autofire is compiled in when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_mux #(
    parameter int NUM_PLAYERS   = 2,
    parameter int NUM_BUTTONS   = 3,
    parameter int COIN_HOLD     = 800000,
    parameter int KEYMAP_INDEX  = 253,
    parameter int DIP_INDEX     = 254,
    parameter int AUTOFIRE_HALF = 2000000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [10:0]                      ps2_key,
    input  logic [16*NUM_PLAYERS-1:0]        joystick,
    input  logic [24:0]                      ioctl_addr,
    input  logic [7:0]                       ioctl_data,
    input  logic                             ioctl_wr,
    input  logic [7:0]                       ioctl_index,
    input  logic [NUM_BUTTONS-1:0]           autofire_mask,
    output logic [4*NUM_PLAYERS-1:0]         joy_out,
    output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] buttons_out,
    output logic [NUM_PLAYERS-1:0]           start_out,
    output logic [NUM_PLAYERS-1:0]           coin_out,
    output logic                             pause_out,
    output logic [63:0]                      dip
);

    localparam int NSLOT = 16 * NUM_PLAYERS;
    localparam int AW    = $clog2(NSLOT);
    localparam int CW    = $clog2(COIN_HOLD + 1);

    logic [7:0]             keymap [NSLOT];
    logic [NSLOT-1:0]       key_state;
    logic                   strobe_q;
    logic [NSLOT-1:0]       raw;
    logic [CW-1:0]          coin_cnt [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] coin_prev;
    logic [NUM_BUTTONS-1:0] fire_gate;
    logic                   pause_any;
    logic                   unused_bits;

    logic          keymap_wr;
    logic          dip_wr;
    logic [AW-1:0] keymap_addr;
    logic          key_event;

    assign keymap_wr   = ioctl_wr && (ioctl_index == 8'(KEYMAP_INDEX)) && (ioctl_addr < 25'(NSLOT));
    assign dip_wr      = ioctl_wr && (ioctl_index == 8'(DIP_INDEX)) && (ioctl_addr[24:3] == '0);
    assign keymap_addr = ioctl_addr[AW-1:0];
    assign key_event   = (ps2_key[10] != strobe_q) && (ps2_key[7:0] != 8'h00);

    function automatic logic [7:0] default_code(input int idx);
        case (idx)
            0:  return 8'h74;
            1:  return 8'h6B;
            2:  return 8'h72;
            3:  return 8'h75;
            4:  return 8'h14;
            5:  return 8'h11;
            6:  return 8'h29;
            10: return 8'h16;
            11: return 8'h2E;
            12: return 8'h4D;
            16: return 8'h34;
            17: return 8'h23;
            18: return 8'h2B;
            19: return 8'h2D;
            20: return 8'h1C;
            21: return 8'h1B;
            22: return 8'h15;
            26: return 8'h1E;
            27: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Keymap table: defaults on reset, single-entry writes from ioctl downloads
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSLOT; i++) keymap[i] <= default_code(i);
        end else if (keymap_wr) begin
            keymap[keymap_addr] <= ioctl_data;
        end
    end

    // Key states follow matching scancodes on a strobe toggle; a keymap write clears its slot
    always_ff @(posedge clk) begin
        strobe_q <= ps2_key[10];
        if (reset) begin
            key_state <= '0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (key_event && keymap[i] == ps2_key[7:0]) key_state[i] <= ps2_key[9];
            end
            if (keymap_wr) key_state[keymap_addr] <= 1'b0;
        end
    end

    // DIP byte capture from the first eight download addresses
    always_ff @(posedge clk) begin
        if (reset) begin
            dip <= '0;
        end else if (dip_wr) begin
            dip[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_data;
        end
    end

    // Raw function bits, pause merge, and collection of unused slots
    always_comb begin
        raw         = key_state | joystick;
        pause_any   = 1'b0;
        unused_bits = ps2_key[8];
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            pause_any = pause_any | raw[16*p+12];
            for (int f = 4 + NUM_BUTTONS; f < 16; f++) begin
                if (f < 10 || f > 12) unused_bits = unused_bits ^ raw[16*p+f];
            end
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int AFW = $clog2(AUTOFIRE_HALF + 1);
    logic [AFW-1:0] af_cnt;
    logic           af_phase;

    // Free-running autofire timebase; phase flips every AUTOFIRE_HALF cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (af_cnt == AFW'(AUTOFIRE_HALF - 1)) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt + AFW'(1);
        end
    end

    assign fire_gate = ~autofire_mask | {NUM_BUTTONS{af_phase}};
`else
    logic unused_mask;
    assign unused_mask = ^autofire_mask;
    assign fire_gate   = '1;
`endif

    // Registered per-player outputs and coin pulse stretching
    always_ff @(posedge clk) begin
        if (reset) begin
            joy_out     <= '0;
            buttons_out <= '0;
            start_out   <= '0;
            coin_out    <= '0;
            coin_prev   <= '0;
            pause_out   <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) coin_cnt[p] <= '0;
        end else begin
            pause_out <= pause_any;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                joy_out[4*p +: 4] <= {raw[16*p+3], raw[16*p+2], raw[16*p+0], raw[16*p+1]};
                buttons_out[NUM_BUTTONS*p +: NUM_BUTTONS] <= raw[16*p+4 +: NUM_BUTTONS] & fire_gate;
                start_out[p] <= raw[16*p+10];
                coin_prev[p] <= raw[16*p+11];
                coin_out[p]  <= raw[16*p+11] | (coin_cnt[p] != '0);
                if (raw[16*p+11] && !coin_prev[p]) begin
                    coin_cnt[p] <= CW'(COIN_HOLD);
                end else if (coin_cnt[p] != '0) begin
                    coin_cnt[p] <= coin_cnt[p] - CW'(1);
                end
            end
        end
    end

endmodule
